// File: rtl/definitions_pkg.sv
// rtl/definitions_pkg.sv - shared tiny5 memory-side types and constants
package definitions;

  typedef enum logic [1:0] {
    MEM_ACCESS_SIZE_BYTE = 2'd0,
    MEM_ACCESS_SIZE_HALF = 2'd1,
    MEM_ACCESS_SIZE_WORD = 2'd2
  } mem_access_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_arb_state_t;

  localparam int MEM_ARB_MAX_LATENCY = 4;

endpackage

// File: rtl/memory_array_interface.sv
// rtl/memory_array_interface.sv - single read/write port onto the memory array
interface memory_array_interface;
  import definitions::*;

  logic [31:0]      rd_addr;
  mem_access_size_t rd_size;
  logic [31:0]      rd_data;
  logic [31:0]      wr_addr;
  mem_access_size_t wr_size;
  logic [31:0]      wr_data;
  logic             wr_enable;

  modport master (
    output rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
    input  rd_data
  );

  modport slave (
    input  rd_addr, rd_size, wr_addr, wr_size, wr_data, wr_enable,
    output rd_data
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant, one-hot, purely combinational
module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin sharing of one memory array port between fetch and load/store
module memory_arbiter
  import definitions::*;
#(
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_addr,
  input  mem_access_size_t req0_size,
  input  logic             req0_we,
  input  logic [31:0]      req0_wdata,
  output logic             resp0_valid,
  output logic [31:0]      resp0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_addr,
  input  mem_access_size_t req1_size,
  input  logic             req1_we,
  input  logic [31:0]      req1_wdata,
  output logic             resp1_valid,
  output logic [31:0]      resp1_data,
  memory_array_interface.master mem
);

  localparam int            CW         = $clog2(MEM_ARB_MAX_LATENCY);
  localparam logic [CW-1:0] COUNT_INIT = CW'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > MEM_ARB_MAX_LATENCY) begin : g_bad_latency
    $error("memory_arbiter: LATENCY must be in 1..MEM_ARB_MAX_LATENCY");
  end

  mem_arb_state_t   state;
  mem_arb_state_t   state_next;
  logic             last_grant;
  logic [CW-1:0]    count;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  mem_access_size_t lat_size;
  logic             lat_we;
  logic             lat_port;
  logic [31:0]      resp_data;
  logic [1:0]       grant;
  logic             grantable;
  logic             accept;

  rr_arbiter2 u_rr (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign grantable  = (state != BUSY);
  assign req0_ready = grantable & grant[0];
  assign req1_ready = grantable & grant[1];
  assign accept     = grantable & (|grant);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (count == '0) state_next = RESP;
      RESP:    state_next = accept ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_size   <= MEM_ACCESS_SIZE_WORD;
      lat_we     <= 1'b0;
      lat_port   <= 1'b0;
      resp_data  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_port   <= grant[1];
        last_grant <= grant[1];
        lat_addr   <= grant[1] ? req1_addr  : req0_addr;
        lat_wdata  <= grant[1] ? req1_wdata : req0_wdata;
        lat_size   <= grant[1] ? req1_size  : req0_size;
        lat_we     <= grant[1] ? req1_we    : req0_we;
        count      <= COUNT_INIT;
      end else if (state == BUSY) begin
        // Array data is registered here so nothing downstream sees rd_data combinationally.
        if (count != '0) begin
          count <= count - 1'b1;
        end else begin
          resp_data <= lat_we ? '0 : mem.rd_data;
        end
      end
    end
  end

  assign mem.rd_addr   = lat_addr;
  assign mem.wr_addr   = lat_addr;
  assign mem.rd_size   = lat_size;
  assign mem.wr_size   = lat_size;
  assign mem.wr_data   = lat_wdata;
  // The counter still holds its load value only in the first BUSY cycle: one write pulse.
  assign mem.wr_enable = (state == BUSY) && (count == COUNT_INIT) && lat_we;

  assign resp0_valid = (state == RESP) && !lat_port;
  assign resp1_valid = (state == RESP) &&  lat_port;
  assign resp0_data  = resp_data;
  assign resp1_data  = resp_data;

endmodule
